la_iopwrseq: RTL and testbench

// - IO-ring power sequencer. It sits directly downstream of the ring supply cells (vddio/vssio/vdda/vssa).
// - Qualifies the supply-good flags and drives ordered control bits onto the generic ioring bus.
// - Power-up order: isolation release -> pad enable -> analog enable. Power-down is the reverse order.
// - Any supply fault forces all ring controls safe.

---
 rtl/la_iopwrseq_pkg.sv | 26 ++
 rtl/la_iopwrseq_cnt.sv | 28 ++
 rtl/la_iopwrseq.sv | 141 ++++++++++++++
 tb/tb_la_iopwrseq.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/la_iopwrseq_pkg.sv
// Shared types and constants for the IO-ring power sequencer.
package la_iopwrseq_pkg;

  typedef enum logic [3:0] {
    OFF, DBNC_WAIT, UP_ISO, UP_PAD, UP_ANA, ON, DN_ANA, DN_PAD, DN_ISO, FAULT
  } state_e;

  localparam int RING_ISO_N  = 0;
  localparam int RING_PAD_EN = 1;
  localparam int RING_ANA_EN = 2;

  // Control bits held in each state; a DN_* state keeps its own bit high
  // for the whole step and it drops when the step completes.
  function automatic logic [2:0] ring_of(input state_e s);
    logic [2:0] r;
    r = 3'b000;
    case (s)
      UP_ISO, DN_ISO:                 r[RING_ISO_N] = 1'b1;
      UP_PAD, DN_PAD:                 r = 3'b011;
      UP_ANA, ON, DN_ANA:             r = 3'b111;
      default:                        r = 3'b000;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/la_iopwrseq_cnt.sv
// Shared debounce/step counter: clear wins over increment, saturates at term.
module la_iopwrseq_cnt #(
  parameter int CNTW = 5
) (
  input  logic            clk,
  input  logic            nreset,
  input  logic            clr,
  input  logic            inc,
  input  logic [CNTW-1:0] term,
  output logic            hit
);

  logic [CNTW-1:0] cnt_q, cnt_d;

  assign hit = (cnt_q == term);

  always_comb begin
    cnt_d = cnt_q;
    if (clr)             cnt_d = '0;
    else if (inc && !hit) cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!nreset) cnt_q <= '0;
    else         cnt_q <= cnt_d;
  end

endmodule

// File: rtl/la_iopwrseq.sv
// IO-ring power sequencer: debounce supplies, ordered ring enable/disable, fault safing.
// Optional macro LA_IOPWRSEQ_SYNC_EN adds a 2-flop synchronizer on each supply flag.
module la_iopwrseq
  import la_iopwrseq_pkg::*;
#(
  parameter int RINGW = 8,
  parameter int DBNC  = 16,
  parameter int STEP  = 8
) (
  input  logic             clk,
  input  logic             nreset,
  input  logic             req_on,
  input  logic             vddio_ok,
  input  logic             vdda_ok,
  output logic [RINGW-1:0] ioring,
  output logic             ready,
  output logic             fault
);

  localparam int CNTW = $clog2((DBNC > STEP) ? DBNC : STEP) + 1;

  logic sup_ok;

`ifdef LA_IOPWRSEQ_SYNC_EN
  logic [1:0] s1_q, s1_d, s2_q, s2_d;

  always_comb begin
    s1_d = {vdda_ok, vddio_ok};
    s2_d = s1_q;
  end

  always_ff @(posedge clk) begin
    if (!nreset) begin
      s1_q <= '0;
      s2_q <= '0;
    end else begin
      s1_q <= s1_d;
      s2_q <= s2_d;
    end
  end

  assign sup_ok = &s2_q;
`else
  assign sup_ok = vddio_ok & vdda_ok;
`endif

  state_e           state_q, state_d;
  logic [RINGW-1:0] ioring_q, ioring_d;
  logic             ready_q, ready_d, fault_q, fault_d;
  logic             cnt_clr, cnt_inc, cnt_hit;
  logic [CNTW-1:0]  cnt_term;

  la_iopwrseq_cnt #(.CNTW(CNTW)) u_cnt (
    .clk    (clk),
    .nreset (nreset),
    .clr    (cnt_clr),
    .inc    (cnt_inc),
    .term   (cnt_term),
    .hit    (cnt_hit)
  );

  always_comb begin
    state_d  = state_q;
    cnt_clr  = 1'b0;
    cnt_inc  = 1'b0;
    cnt_term = CNTW'(STEP - 1);
    case (state_q)
      OFF: if (req_on) state_d = DBNC_WAIT;
      DBNC_WAIT: begin
        cnt_term = CNTW'(DBNC - 1);
        cnt_inc  = sup_ok;
        cnt_clr  = !sup_ok;
        if (!req_on)               state_d = OFF;
        else if (sup_ok && cnt_hit) state_d = UP_ISO;
      end
      UP_ISO, UP_PAD, UP_ANA: begin
        cnt_inc = 1'b1;
        if (!sup_ok) state_d = FAULT;
        else if (!req_on) begin
          // abort from the highest control bit already driven
          case (state_q)
            UP_ISO:  state_d = DN_ISO;
            UP_PAD:  state_d = DN_PAD;
            default: state_d = DN_ANA;
          endcase
        end else if (cnt_hit) begin
          case (state_q)
            UP_ISO:  state_d = UP_PAD;
            UP_PAD:  state_d = UP_ANA;
            default: state_d = ON;
          endcase
        end
      end
      ON: begin
        if (!sup_ok)      state_d = FAULT;
        else if (!req_on) state_d = DN_ANA;
      end
      DN_ANA, DN_PAD, DN_ISO: begin
        cnt_inc = 1'b1;
        if (!sup_ok) state_d = FAULT;
        else if (cnt_hit) begin
          case (state_q)
            DN_ANA:  state_d = DN_PAD;
            DN_PAD:  state_d = DN_ISO;
            default: state_d = OFF;
          endcase
        end
      end
      FAULT: if (!req_on) state_d = OFF;
      default: state_d = OFF;
    endcase
    if (state_d != state_q) cnt_clr = 1'b1;
  end

  // Outputs decode the next state so they change on the same edge as the FSM.
  always_comb begin
    ioring_d      = '0;
    ioring_d[2:0] = ring_of(state_d);
    ready_d       = (state_d == ON);
    fault_d       = (state_d == FAULT);
  end

  always_ff @(posedge clk) begin
    if (!nreset) begin
      state_q  <= OFF;
      ioring_q <= '0;
      ready_q  <= 1'b0;
      fault_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      ioring_q <= ioring_d;
      ready_q  <= ready_d;
      fault_q  <= fault_d;
    end
  end

  assign ioring = ioring_q;
  assign ready  = ready_q;
  assign fault  = fault_q;

endmodule

// File: tb/tb_la_iopwrseq.sv
// Self-checking bench for la_iopwrseq: level/timer reference model plus directed timing checks.
module tb_la_iopwrseq;

  localparam int RINGW = 8;
  localparam int DBNC  = 16;
  localparam int STEP  = 8;
`ifdef LA_IOPWRSEQ_SYNC_EN
  localparam int SLAT = 2;
`else
  localparam int SLAT = 0;
`endif

  logic             clk = 1'b0;
  logic             nreset, req_on, vddio_ok, vdda_ok;
  logic [RINGW-1:0] ioring;
  logic             ready, fault;

  la_iopwrseq #(.RINGW(RINGW), .DBNC(DBNC), .STEP(STEP)) dut (
    .clk(clk), .nreset(nreset), .req_on(req_on), .vddio_ok(vddio_ok),
    .vdda_ok(vdda_ok), .ioring(ioring), .ready(ready), .fault(fault)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  bit chk_en = 1'b0;

  // Reference: mode 0 idle, 1 debounce, 2 rising, 3 on, 4 falling, 5 fault.
  // lvl = number of ring bits enabled (ring = 2^lvl - 1).
  int   mode = 0, lvl = 0, tmr = 0;
  logic p1 = 1'b0, p2 = 1'b0;

  always @(posedge clk) begin
    logic sup;
`ifdef LA_IOPWRSEQ_SYNC_EN
    sup = p2;
    p2  = p1;
    p1  = vddio_ok & vdda_ok;
`else
    sup = vddio_ok & vdda_ok;
`endif
    if (!nreset) begin
      mode = 0; lvl = 0; tmr = 0; p1 = 1'b0; p2 = 1'b0;
    end else begin
      case (mode)
        0: if (req_on) begin mode = 1; tmr = 0; end
        1: begin
          if (!req_on) begin mode = 0; tmr = 0; end
          else if (!sup) tmr = 0;
          else if (tmr == DBNC-1) begin mode = 2; lvl = 1; tmr = 0; end
          else tmr++;
        end
        2, 3, 4: begin
          if (!sup) begin mode = 5; lvl = 0; tmr = 0; end
          else if (mode != 4 && !req_on) begin mode = 4; tmr = 0; end
          else if (mode == 2) begin
            if (tmr == STEP-1) begin
              tmr = 0;
              if (lvl == 3) mode = 3; else lvl++;
            end else tmr++;
          end else if (mode == 4) begin
            if (tmr == STEP-1) begin
              tmr = 0; lvl--;
              if (lvl == 0) mode = 0;
            end else tmr++;
          end
        end
        default: if (!req_on) mode = 0;
      endcase
    end
  end

  always @(negedge clk) begin
    logic [RINGW-1:0] er;
    if (chk_en) begin
      er = RINGW'((1 << lvl) - 1);
      total++;
      if (ioring !== er || ready !== (mode == 3) || fault !== (mode == 5)) begin
        bad++;
        $display("FAIL model t=%0t: ioring=%b ready=%b fault=%b, want ioring=%b ready=%b fault=%b",
                 $time, ioring, ready, fault, er, (mode == 3), (mode == 5));
      end
    end
  end

  function automatic logic sig(input int w);
    case (w)
      0, 1, 2: return ioring[w];
      3:       return ready;
      default: return fault;
    endcase
  endfunction

  task automatic chk(input string name, input int act, input int req);
    total++;
    if (act != req) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", name, act, req);
    end
  endtask

  task automatic tick();
    @(posedge clk); @(negedge clk);
  endtask

  task automatic wait_sig(input int w, input logic v, input int budget, output int n);
    n = 0;
    do begin tick(); n++; end while (sig(w) !== v && n < budget);
  endtask

  // Reset with random inputs, then park in OFF with good supplies.
  task automatic do_reset();
    nreset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      req_on = 1'($urandom); vddio_ok = 1'($urandom); vdda_ok = 1'($urandom);
      @(posedge clk); chk_en = 1'b1; @(negedge clk);
    end
    chk("reset_ioring", int'(ioring), 0);
    chk("reset_ready",  int'(ready),  0);
    chk("reset_fault",  int'(fault),  0);
    req_on = 1'b0; vddio_ok = 1'b1; vdda_ok = 1'b1;
    tick();
    nreset = 1'b1;
    repeat (4) tick();
  endtask

  task automatic power_up();
    int n;
    req_on = 1'b1;
    wait_sig(3, 1'b1, 200, n);
    chk("power_up_reaches_on", int'(ready), 1);
  endtask

  initial begin
    int n;
    nreset = 1'b0; req_on = 1'b0; vddio_ok = 1'b0; vdda_ok = 1'b0;
    @(negedge clk);

    // clean power-up timing
    do_reset();
    req_on = 1'b1;
    tick();
    wait_sig(0, 1'b1, 100, n); chk("up_iso_delay", n, 16);
    wait_sig(1, 1'b1, 100, n); chk("up_pad_delay", n, 8);
    wait_sig(2, 1'b1, 100, n); chk("up_ana_delay", n, 8);
    wait_sig(3, 1'b1, 100, n); chk("up_ready_delay", n, 8);

    // ordered power-down
    req_on = 1'b0;
    tick();
    chk("dn_ready_at_once", int'(ready), 0);
    chk("dn_ring_held", int'(ioring), 7);
    wait_sig(2, 1'b0, 100, n); chk("dn_ana_delay", n, 8);
    wait_sig(1, 1'b0, 100, n); chk("dn_pad_delay", n, 8);
    wait_sig(0, 1'b0, 100, n); chk("dn_iso_delay", n, 8);
    tick();
    chk("dn_off_ring", int'(ioring), 0);

    // debounce glitch at count 10
    do_reset();
    req_on = 1'b1;
    tick();
    repeat (10) tick();
    vdda_ok = 1'b0;
    tick();
    vdda_ok = 1'b1;
    wait_sig(0, 1'b1, 100, n); chk("glitch_restart_delay", n, 16 + SLAT);

    // supply fault from ON
    do_reset();
    power_up();
    vddio_ok = 1'b0;
    wait_sig(4, 1'b1, 20, n); chk("fault_latency", n, 1 + SLAT);
    chk("fault_ring_safe", int'(ioring), 0);
    chk("fault_ready_low", int'(ready), 0);
    vddio_ok = 1'b1;
    repeat (5) tick();
    chk("fault_sticky", int'(fault), 1);
    req_on = 1'b0;
    tick();
    chk("fault_exit", int'(fault), 0);

    // early abort from UP_PAD
    do_reset();
    req_on = 1'b1;
    wait_sig(1, 1'b1, 100, n);
    req_on = 1'b0;
    tick();
    chk("abort_ring_held", int'(ioring), 3);
    wait_sig(1, 1'b0, 100, n); chk("abort_pad_delay", n, 8);
    chk("abort_ana_clear", int'(ioring[2]), 0);
    wait_sig(0, 1'b0, 100, n); chk("abort_iso_delay", n, 8);

    // randomized traffic against the model
    do_reset();
    for (int i = 0; i < 5000; i++) begin
      if ($urandom_range(0, 39) == 0) req_on = ~req_on;
      vddio_ok = vddio_ok ? ($urandom_range(0, 199) != 0) : ($urandom_range(0, 4) == 0);
      vdda_ok  = vdda_ok  ? ($urandom_range(0, 199) != 0) : ($urandom_range(0, 4) == 0);
      nreset   = ($urandom_range(0, 999) != 0);
      tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
